hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It issues per-stage write-enable and flush (bubble) controls to the PC, IF/ID, ID/EX, EX/M and M/WB registers. It covers load-use stalls, EX-stage redirects, data-memory wait freezes and multi-cycle EX operations (mul/div). It sits beside the operand-forwarding unit, which resolves all other RAW hazards, and handles only the cases forwarding cannot.

## Interface
Parameters:
- MD_LAT, 4: EX occupancy in cycles of a multi-cycle op; legal range 2..255.
- CNT_W, 32: width of the stall performance counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_hazard_IFID_Rs1  in  5  rs1 of the instruction in IF/ID.
- i_hazard_IFID_Rs2  in  5  rs2 of the instruction in IF/ID.
- i_hazard_IFID_UseRs1  in  1  IF/ID instruction reads rs1.
- i_hazard_IFID_UseRs2  in  1  IF/ID instruction reads rs2.
- i_hazard_IDEX_RegDst  in  5  rd of the instruction in ID/EX.
- i_hazard_IDEX_MemRdEn  in  1  ID/EX instruction is a load.
- i_hazard_IDEX_MdStart  in  1  ID/EX instruction is a multi-cycle op.
- i_hazard_EX_Redirect  in  1  branch taken or jump resolved in EX.
- i_hazard_DMem_Busy  in  1  data memory not ready for the M-stage access.
- o_hazard_PCWrEn  out  1  PC update enable.
- o_hazard_IFIDWrEn  out  1  IF/ID write enable.
- o_hazard_IFIDFlush  out  1  IF/ID loads a NOP.
- o_hazard_IDEXWrEn  out  1  ID/EX write enable.
- o_hazard_IDEXFlush  out  1  ID/EX loads a bubble.
- o_hazard_EXMWrEn  out  1  EX/M write enable.
- o_hazard_EXMFlush  out  1  EX/M loads a bubble.
- o_hazard_MWBFlush  out  1  M/WB loads a bubble.
- o_hazard_MdDone  out  1  final EX cycle of a multi-cycle op.
- o_hazard_State  out  2  FSM state: 00 RUN, 01 MD_BUSY.
- o_hazard_StallCnt  out  CNT_W  saturating count of cycles with PCWrEn=0.

## Operation
- State is a 2-state FSM (RUN, MD_BUSY) plus an 8-bit down-counter `md_cnt`.
- Default in RUN:
  - All WrEn = 1, all Flush = 0, MdDone = 0.
- Per-cycle priority, highest first:
  1. **DMem_Busy = 1 (any state):**
     - PC, IF/ID, ID/EX and EX/M WrEn = 0; MWBFlush = 1; all other flushes 0.
     - State and `md_cnt` hold.
     - MdDone = 0, even when `md_cnt` = 0.
  2. **MD_BUSY, `md_cnt` != 0:**
     - PC, IF/ID and ID/EX WrEn = 0; EXMFlush = 1.
     - `md_cnt` decrements.
  3. **MD_BUSY, `md_cnt` = 0:**
     - MdDone = 1, all WrEn = 1, no flushes; next state RUN.
     - MdStart is ignored in this cycle.
  4. **RUN, EX_Redirect = 1:**
     - IFIDFlush = 1 and IDEXFlush = 1; PCWrEn = 1 (loads the target).
     - Load-use detection and MdStart are ignored.
  5. **RUN, MdStart = 1:**
     - PC, IF/ID and ID/EX WrEn = 0; EXMFlush = 1.
     - Next state MD_BUSY with `md_cnt` = MD_LAT-2.
  6. **RUN, load-use:**
     - Condition: IDEX_MemRdEn && IDEX_RegDst != 0 && ((UseRs1 && Rs1 == RegDst) || (UseRs2 && Rs2 == RegDst)).
     - Response: PCWrEn = 0, IFIDWrEn = 0, IDEXFlush = 1.
     - Exactly one bubble; the forwarding unit supplies the load data afterwards.
- Register x0 never creates a load-use hazard.
- StallCnt increments on every clock edge where PCWrEn = 0 and i_rst = 0. It saturates at all-ones and does not wrap.

## Timing
- All control outputs are combinational from the current state, `md_cnt` and the inputs, within the same cycle.
- State, `md_cnt` and StallCnt update on the rising i_clk edge.
- A multi-cycle op causes exactly MD_LAT-1 stall cycles, plus any DMem_Busy cycles. MdDone is a single-cycle pulse.
- Load-use costs 1 cycle. Redirect costs 2 squashed slots and no stall.
- Reset behaviour:
  - i_rst immediately forces State = RUN, `md_cnt` = 0, StallCnt = 0.
  - While i_rst is high: all WrEn = 0, all Flush = 1, MdDone = 0.
  - Reset during MD_BUSY aborts the operation; there is no MdDone pulse.
- DMem_Busy is the only input that can stall MD_BUSY. The count resumes on the first cycle after Busy drops.

## Test plan
- **Load-use:** IDEX load with RegDst=5, IFID Rs1=5, UseRs1=1 -> one cycle of PCWrEn=0, IFIDWrEn=0, IDEXFlush=1; the next cycle is all-run. Repeat with RegDst=0 -> no stall.
- **Redirect precedence:** EX_Redirect=1 together with a load-use match -> IFIDFlush=1, IDEXFlush=1, PCWrEn=1; StallCnt unchanged.
- **Multi-cycle op:** MD_LAT=4, MdStart pulse in RUN -> 3 stall cycles with EXMFlush=1, then MdDone=1 in cycle 4; State sequence 00,01,01,01 -> 00; StallCnt += 3.
- **Memory wait inside MD_BUSY:** DMem_Busy=1 for 2 cycles in the middle of a multi-cycle op -> PC, IF/ID, ID/EX and EX/M WrEn=0, MWBFlush=1, `md_cnt` frozen; MdDone is delayed exactly 2 cycles.
- **Reset mid-operation:** assert i_rst asynchronously in MD_BUSY -> State=00 and StallCnt=0 immediately, all Flush=1; after release, MdStart=0 gives all WrEn=1.
- **Saturation:** CNT_W=4 with 20 consecutive load-use stalls -> StallCnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencing for the 5-stage RV32I core
module hazard_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_hazard_IFID_Rs1,
    input  logic [4:0]       i_hazard_IFID_Rs2,
    input  logic             i_hazard_IFID_UseRs1,
    input  logic             i_hazard_IFID_UseRs2,
    input  logic [4:0]       i_hazard_IDEX_RegDst,
    input  logic             i_hazard_IDEX_MemRdEn,
    input  logic             i_hazard_IDEX_MdStart,
    input  logic             i_hazard_EX_Redirect,
    input  logic             i_hazard_DMem_Busy,
    output logic             o_hazard_PCWrEn,
    output logic             o_hazard_IFIDWrEn,
    output logic             o_hazard_IFIDFlush,
    output logic             o_hazard_IDEXWrEn,
    output logic             o_hazard_IDEXFlush,
    output logic             o_hazard_EXMWrEn,
    output logic             o_hazard_EXMFlush,
    output logic             o_hazard_MWBFlush,
    output logic             o_hazard_MdDone,
    output logic [1:0]       o_hazard_State,
    output logic [CNT_W-1:0] o_hazard_StallCnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_BUSY = 2'b01
    } state_t;

    localparam logic [7:0] MD_INIT = 8'(MD_LAT - 2);

    state_t           state, state_nxt;
    logic [7:0]       md_cnt, md_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use;

    // x0 is hardwired zero, so a load targeting it never produces a dependency
    assign load_use = i_hazard_IDEX_MemRdEn && (i_hazard_IDEX_RegDst != 5'd0) &&
                      ((i_hazard_IFID_UseRs1 && (i_hazard_IFID_Rs1 == i_hazard_IDEX_RegDst)) ||
                       (i_hazard_IFID_UseRs2 && (i_hazard_IFID_Rs2 == i_hazard_IDEX_RegDst)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (!o_hazard_PCWrEn && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt          = state;
        md_cnt_nxt         = md_cnt;
        o_hazard_PCWrEn    = 1'b1;
        o_hazard_IFIDWrEn  = 1'b1;
        o_hazard_IFIDFlush = 1'b0;
        o_hazard_IDEXWrEn  = 1'b1;
        o_hazard_IDEXFlush = 1'b0;
        o_hazard_EXMWrEn   = 1'b1;
        o_hazard_EXMFlush  = 1'b0;
        o_hazard_MWBFlush  = 1'b0;
        o_hazard_MdDone    = 1'b0;

        if (i_rst) begin
            o_hazard_PCWrEn    = 1'b0;
            o_hazard_IFIDWrEn  = 1'b0;
            o_hazard_IDEXWrEn  = 1'b0;
            o_hazard_EXMWrEn   = 1'b0;
            o_hazard_IFIDFlush = 1'b1;
            o_hazard_IDEXFlush = 1'b1;
            o_hazard_EXMFlush  = 1'b1;
            o_hazard_MWBFlush  = 1'b1;
        end else if (i_hazard_DMem_Busy) begin
            // freeze everything upstream of M/WB; the FSM and md_cnt hold
            o_hazard_PCWrEn   = 1'b0;
            o_hazard_IFIDWrEn = 1'b0;
            o_hazard_IDEXWrEn = 1'b0;
            o_hazard_EXMWrEn  = 1'b0;
            o_hazard_MWBFlush = 1'b1;
        end else if (state == ST_MD_BUSY) begin
            if (md_cnt != 8'd0) begin
                o_hazard_PCWrEn   = 1'b0;
                o_hazard_IFIDWrEn = 1'b0;
                o_hazard_IDEXWrEn = 1'b0;
                o_hazard_EXMFlush = 1'b1;
                md_cnt_nxt        = md_cnt - 8'd1;
            end else begin
                o_hazard_MdDone = 1'b1;
                state_nxt       = ST_RUN;
            end
        end else if (i_hazard_EX_Redirect) begin
            o_hazard_IFIDFlush = 1'b1;
            o_hazard_IDEXFlush = 1'b1;
        end else if (i_hazard_IDEX_MdStart) begin
            // the start cycle is the first of MD_LAT-1 stall cycles
            o_hazard_PCWrEn   = 1'b0;
            o_hazard_IFIDWrEn = 1'b0;
            o_hazard_IDEXWrEn = 1'b0;
            o_hazard_EXMFlush = 1'b1;
            state_nxt         = ST_MD_BUSY;
            md_cnt_nxt        = MD_INIT;
        end else if (load_use) begin
            o_hazard_PCWrEn    = 1'b0;
            o_hazard_IFIDWrEn  = 1'b0;
            o_hazard_IDEXFlush = 1'b1;
        end
    end

    assign o_hazard_State    = state;
    assign o_hazard_StallCnt = stall_cnt;

endmodule
